cd_spi_slave: RTL

//  SPI slave front-end that converts SPI frames into single-cycle CSR accesses on the
//  cd_csr register bus, and drives the chip_select qualifier that cd_csr uses
//  for snapshots and burst completion. It sits directly upstream of cd_csr in the
//  SPI build. All SPI pins are oversampled in the clk domain. The block runs SPI

---
 rtl/cd_spi_slave.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/cd_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : cd_spi_slave
// Description : SPI mode-0 (MSB first) slave front-end that turns SPI frames
//               into single-cycle CSR read/write strobes on the cd_csr bus.
//               All SPI pins are oversampled in the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module cd_spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sclk,
    input  logic       nss,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic       chip_select,
    output logic [4:0] csr_address,
    output logic       csr_read,
    input  logic [7:0] csr_readdata,
    output logic       csr_write,
    output logic [7:0] csr_writedata
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CMD  = 2'd1;
    localparam logic [1:0] c_WR   = 2'd2;
    localparam logic [1:0] c_RD   = 2'd3;

    // Synchroniser chains; nss idles high so its chain resets to ones
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_nss_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_sclk_d;
    logic                   r_armed;

    logic       w_sclk;
    logic       w_mosi;
    logic       w_nss;
    logic       w_cs;
    logic       w_rise;
    logic       w_fall;
    logic       w_fill_done;

    logic [1:0] r_state;
    logic [1:0] w_state_next;

    logic [6:0] r_rx_sr;
    logic [7:0] r_tx_sr;
    logic [2:0] r_bit_cnt;
    logic       r_skip_fall;
    logic [4:0] r_csr_address;
    logic       r_csr_read;
    logic       r_csr_write;
    logic [7:0] r_csr_writedata;

    logic [7:0] w_byte;
    logic       w_byte_end;
    logic       w_load_addr;
    logic       w_read_pulse;
    logic       w_write_pulse;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_nss       = r_nss_sync[SYNC_STAGES-1];
    assign w_cs        = ~w_nss;
    assign w_rise      = w_sclk & ~r_sclk_d;
    assign w_fall      = ~w_sclk & r_sclk_d;
    // r_fill reaches all-ones once every sync stage holds a real pin sample
    assign w_fill_done = r_fill[SYNC_STAGES-1];

    // Byte as it stands including the bit arriving on this rise
    assign w_byte      = {r_rx_sr, w_mosi};
    assign w_byte_end  = w_rise && (r_bit_cnt == 3'd7) && w_cs;

    assign chip_select   = w_cs;
    assign miso          = r_tx_sr[7];
    assign csr_address   = r_csr_address;
    assign csr_read      = r_csr_read;
    assign csr_write     = r_csr_write;
    assign csr_writedata = r_csr_writedata;

    // Pin synchronisers, sclk edge history and the "nss seen high" arming flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_nss_sync  <= '1;
            r_fill      <= '0;
            r_sclk_d    <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_nss_sync  <= {r_nss_sync[SYNC_STAGES-2:0], nss};
            r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_sclk_d    <= w_sclk;
            if (w_fill_done && w_nss) begin
                r_armed <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: the command byte decides between write and read phases
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (r_armed && w_cs) begin
                    w_state_next = c_CMD;
                end
            end
            c_CMD: begin
                if (!w_cs) begin
                    w_state_next = c_IDLE;
                end else if (w_byte_end) begin
                    w_state_next = w_byte[7] ? c_WR : c_RD;
                end
            end
            c_WR, c_RD: begin
                if (!w_cs) begin
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // FSM outputs: byte-boundary decodes that become next-cycle strobes
    always_comb begin
        w_load_addr   = 1'b0;
        w_read_pulse  = 1'b0;
        w_write_pulse = 1'b0;
        miso_oe       = (r_state != c_IDLE);
        if (w_byte_end) begin
            case (r_state)
                c_CMD: begin
                    w_load_addr  = 1'b1;
                    w_read_pulse = ~w_byte[7];
                end
                c_RD:    w_read_pulse  = 1'b1;
                c_WR:    w_write_pulse = 1'b1;
                default: w_load_addr   = 1'b0;
            endcase
        end
    end

    // Shift registers, bit counter and CSR strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_sr         <= '0;
            r_tx_sr         <= '0;
            r_bit_cnt       <= '0;
            r_skip_fall     <= 1'b0;
            r_csr_address   <= '0;
            r_csr_read      <= 1'b0;
            r_csr_write     <= 1'b0;
            r_csr_writedata <= '0;
        end else begin
            r_csr_read  <= w_read_pulse;
            r_csr_write <= w_write_pulse;
            if (w_load_addr) begin
                r_csr_address <= w_byte[4:0];
            end
            if (w_write_pulse) begin
                r_csr_writedata <= w_byte;
            end
            // Outside a frame the bit position restarts and dummy zeros are queued
            if ((r_state == c_IDLE) || !w_cs) begin
                r_bit_cnt   <= '0;
                r_tx_sr     <= '0;
                r_skip_fall <= 1'b0;
            end else begin
                if (w_rise) begin
                    r_rx_sr   <= w_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                // A freshly loaded byte already presents bit7, so the trailing
                // fall of the previous byte must not shift it away
                if (r_csr_read) begin
                    r_tx_sr     <= csr_readdata;
                    r_skip_fall <= 1'b1;
                end else if (w_fall) begin
                    if (r_skip_fall) begin
                        r_skip_fall <= 1'b0;
                    end else begin
                        r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire
